// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader and benches that pair it with memProcessing.
package frame_loader_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    START = 2'b01,
    SEND  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam int NBYTES_DEF       = 8;
  localparam int DRAIN_CYCLES_DEF = 10;

endpackage

// File: rtl/frame_loader_frame_buf.sv
// Frame buffer: NBYTES x DW register file, one synchronous write port, one combinational read port.
module frame_buf #(
  parameter int NBYTES = 8,
  parameter int DW     = 8,
  parameter int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NBYTES];

  // Contents are deliberately not reset; every byte is rewritten before it is replayed.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_loader.sv
// Collects one NBYTES frame from a valid/ready byte stream, pulses Init, replays it on DataInA, then drains.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int NBYTES       = NBYTES_DEF,
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          Init,
  output logic [DW-1:0] DataInA,
  output logic          busy,
  output logic [7:0]    frame_count
);

  localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PW-1:0] WR_LAST    = PW'(NBYTES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [CW-1:0] drain_cnt;
  logic [DW-1:0] rd_data;
  logic          accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) state <= FILL;
    else       state <= state_nxt;
  end

  // SEND ends when rd_ptr wraps back to zero, so NBYTES is expected to be a power of two.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (accept && wr_ptr == WR_LAST) state_nxt = START;
      START: state_nxt = SEND;
      SEND:  if (rd_ptr == '0) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state == FILL);
    Init     = (state == START);
    busy     = (state != FILL);
  end

  // Byte 0 is fetched during START so it lands on DataInA in the first SEND cycle.
  assign rd_addr = (state == START) ? '0 : rd_ptr;

  frame_buf #(
    .NBYTES(NBYTES),
    .DW    (DW),
    .PW    (PW)
  ) u_buf (
    .clock(clock),
    .we   (accept),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      drain_cnt   <= '0;
      frame_count <= '0;
      DataInA     <= '0;
    end else begin
      DataInA <= (state_nxt == SEND) ? rd_data : '0;
      case (state)
        FILL:  if (accept) wr_ptr <= wr_ptr + PW'(1);
        START: rd_ptr <= PW'(1);
        SEND:  rd_ptr <= rd_ptr + PW'(1);
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt   <= '0;
            frame_count <= frame_count + 8'd1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Table-driven bench for frame_loader: per-cycle vectors plus reset-mid-SEND and frame_count wrap sequences.
module tb_frame_loader;

  logic       clock = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       Init;
  logic [7:0] DataInA;
  logic       busy;
  logic [7:0] frame_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       ini;
    logic [7:0] dout;
    logic       bsy;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  frame_loader #(.NBYTES(8), .DW(8), .DRAIN_CYCLES(10)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .Init       (Init),
    .DataInA    (DataInA),
    .busy       (busy),
    .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic ini,
                     input logic [7:0] dout, input logic bsy, input logic [7:0] fc);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.ini = ini; r.dout = dout; r.bsy = bsy; r.fc = fc;
    tbl.push_back(r);
  endtask

  // One frame worth of cycles: fill (optionally gapped), START, 8 SEND, 10 DRAIN.
  // With bp set, in_valid stays high with incrementing data outside FILL.
  task automatic add_frame(input logic [7:0] first, input bit gapped, input bit bp,
                           input logic [7:0] fc0);
    logic [7:0] nd;
    nd = first + 8'd8;
    for (int k = 0; k < 8; k++) begin
      if (gapped) add(1'b0, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, fc0);
      add(1'b1, first + 8'(k), 1'b1, 1'b0, 8'h00, 1'b0, fc0);
    end
    add(bp, nd, 1'b0, 1'b1, 8'h00, 1'b1, fc0);
    nd++;
    for (int k = 0; k < 8; k++) begin
      add(bp, nd, 1'b0, 1'b0, first + 8'(k), 1'b1, fc0);
      nd++;
    end
    for (int k = 0; k < 10; k++) begin
      add(bp, nd, 1'b0, 1'b0, 8'h00, 1'b1, fc0);
      nd++;
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      chk($sformatf("%s[%0d].in_ready", tag, i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("%s[%0d].Init", tag, i), 32'(Init), 32'(tbl[i].ini));
      chk($sformatf("%s[%0d].DataInA", tag, i), 32'(DataInA), 32'(tbl[i].dout));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("%s[%0d].frame_count", tag, i), 32'(frame_count), 32'(tbl[i].fc));
    end
  endtask

  initial begin
    Reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.Init", 32'(Init), 32'd0);
    chk("reset.DataInA", 32'(DataInA), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.frame_count", 32'(frame_count), 32'd0);
    Reset = 1'b0;

    // Basic, gapped, backpressure, then the frame that must start with the first FILL-cycle byte (8'h4B).
    add_frame(8'h01, 1'b0, 1'b0, 8'd0);
    add_frame(8'hA0, 1'b1, 1'b0, 8'd1);
    add_frame(8'h30, 1'b0, 1'b1, 8'd2);
    add_frame(8'h4B, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4);
    run_table("vec");

    // Reset asserted while byte 4 of SEND is on DataInA.
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(k);
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("rst_mid.Init", 32'(Init), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("rst_mid.byte%0d", k), 32'(DataInA), 32'(8'h50 + 8'(k)));
    end
    Reset = 1'b1;
    #1;
    chk("rst_mid.DataInA", 32'(DataInA), 32'd0);
    chk("rst_mid.Init", 32'(Init), 32'd0);
    chk("rst_mid.frame_count", 32'(frame_count), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    @(negedge clock);
    Reset = 1'b0;
    tbl.delete();
    add_frame(8'h10, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1);
    run_table("after_rst");

    // Continuous input: one frame every 27 cycles, frame_count goes 1 -> 255 -> 0.
    for (int n = 0; n < 255 * 27; n++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'(n);
      if (n == 254 * 27 - 1) chk("wrap.fc_254", 32'(frame_count), 32'd254);
      if (n == 254 * 27) chk("wrap.fc_255", 32'(frame_count), 32'd255);
      if (n == 255 * 27 - 1) chk("wrap.last_drain_busy", 32'(busy), 32'd1);
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("wrap.fc_0", 32'(frame_count), 32'd0);
    chk("wrap.in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream feeder for `memProcessing`. It collects one frame of `NBYTES` bytes from a valid/ready byte stream into a local buffer, then issues a one-cycle `Init` pulse and replays the frame on `DataInA` one byte per cycle, exactly aligned with the READA write window. It then holds off for a fixed drain period while the downstream COMP pass runs, and only then accepts the next frame.

## Interface
Parameters:
- `NBYTES`, 8: bytes per frame; must equal the MemoryA depth downstream (2**3).
- `DW`, 8: data width.
- `DRAIN_CYCLES`, 10: idle cycles after the last byte before the next fill; must be ≥ 9 to cover COMP.

Ports:
- `clock`, input, 1: clock.
- `Reset`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: upstream byte valid.
- `in_data`, input, DW: upstream byte.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `Init`, output, 1: one-cycle start pulse to `memProcessing.Init`.
- `DataInA`, output, DW: byte stream to `memProcessing.DataInA`.
- `busy`, output, 1: high in START, SEND and DRAIN.
- `frame_count`, output, 8: completed frames, wraps 255→0.

## Operation
States, all transitions on `posedge clock`:
- **FILL**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`: `buf[wr_ptr]<=in_data` and `wr_ptr++`.
  - Accepting byte `NBYTES-1` moves to START and sets `wr_ptr<=0`.
- **START**
  - `Init`=1 for exactly one cycle.
  - `rd_ptr<=0`, then move to SEND.
- **SEND**
  - `DataInA` (registered) shows `buf[rd_ptr]`; `rd_ptr++` each cycle.
  - After `NBYTES` cycles, move to DRAIN.
- **DRAIN**
  - `drain_cnt` counts 0..`DRAIN_CYCLES-1`.
  - On its terminal count: move to FILL and increment `frame_count`.

Outputs and handshake rules:
- `in_ready` = (state==FILL), combinational from state only and never from `in_valid`.
- A byte is consumed only on the cycle where both `in_valid` and `in_ready` are high.
- `in_valid` held high outside FILL is ignored, and no byte is lost or duplicated.
- `DataInA` = 0 whenever the loader is not in SEND, so no stale data reaches the downstream block.
- `Init` = (state==START), combinational.

Widths and wrap-around:
- Pointers are `$clog2(NBYTES)` bits and wrap naturally.
- `drain_cnt` is `$clog2(DRAIN_CYCLES)` bits.
- `frame_count` is a plain 8-bit wrapping increment.

Reset behaviour:
- On `Reset` (any time, including mid-SEND): state=FILL, pointers=0, `drain_cnt`=0, `frame_count`=0, `DataInA`=0, `Init`=0.
- `in_ready`=1 as soon as `Reset` deasserts.
- Buffer contents are not cleared.
- A partial frame is discarded.

## Timing
- Let cycle T be the START cycle (`Init`=1). Byte k appears on `DataInA` in cycle T+1+k, for k=0..NBYTES-1. This matches the downstream behaviour: AddrA is cleared at the T edge and writes at the T+1..T+8 edges.
- Fill latency is the time to accept `NBYTES` bytes. With `in_valid` held high, that is `NBYTES` cycles.
- Frame period with continuous input: `NBYTES` + 1 + `NBYTES` + `DRAIN_CYCLES` = 27 cycles at the defaults.
- `busy` rises in cycle T and falls on the cycle FILL is re-entered.
- `frame_count` updates on the DRAIN→FILL edge.

## Structure
- Shared package `frame_loader_pkg` holds:
  - the state enum (FILL=2'b00, START=2'b01, SEND=2'b10, DRAIN=2'b11);
  - the `NBYTES`/`DRAIN_CYCLES` default constants, shared with the `memProcessing` bench.
- The frame buffer is natural as one sub-module, `frame_buf`:
  - `NBYTES`×`DW` register file;
  - one synchronous write port;
  - one combinational read port, registered into `DataInA` by the loader.
- The FSM, pointers and counters live in the top-level `frame_loader`.

## Test plan
- **Basic frame:** `in_valid`=1 with bytes 1..8 on consecutive cycles.
  - `Init` pulses one cycle later.
  - `DataInA` = 1,2,...,8 on the next 8 cycles, then 0.
  - `frame_count`=1 after 10 drain cycles.
- **Gapped input:** bytes 8'hA0..8'hA7 with `in_valid` toggling every other cycle.
  - Exactly 8 bytes are accepted and replayed in order.
  - `Init` is asserted only after the 8th accept.
- **Backpressure:** hold `in_valid`=1 with incrementing data through START/SEND/DRAIN.
  - `in_ready`=0 throughout those states.
  - The second frame begins with the byte presented on the first FILL cycle; no skip or duplicate.
- **Reset mid-SEND:** assert `Reset` at byte 4 of SEND.
  - Outputs clear immediately: `DataInA`=0, `Init`=0, `frame_count`=0.
  - A new full frame of 8'h10..8'h17 replays correctly.
- **End-to-end with `memProcessing`:** feed 10,3,5,5,20,7,1,9.
  - MemoryB = 7 (10-3), 10 (5+5), 13 (20-7), 10 (1+9) before the loader leaves DRAIN.
- **Wrap:** run 256 frames. `frame_count` wraps 255→0.
